// File: rtl/sram_rd_engine.sv
// sram_rd_engine: read-side engine for the packet-buffer SRAM.
// Takes a (start address, word count) descriptor, walks the SRAM with
// wrap-around addressing, and buffers the one-cycle read latency in a
// 2-entry FIFO that feeds a valid/ready stream tagged with SOP/EOP.
module sram_rd_engine #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 16384,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  first_q, first_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_sop_q, infl_sop_d;
  logic                  infl_eop_q, infl_eop_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_sop_q, fifo_sop_d;
  logic [1:0]            fifo_eop_q, fifo_eop_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  // Handshake terms and the credit check: words buffered plus the one in
  // flight, minus the one leaving this cycle, must leave room for another.
  always_comb begin
    out_valid = (fifo_cnt_q != 2'd0);
    pop       = out_valid && out_ready;
    push      = inflight_q;
    occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == READ) && (remain_q != '0) && (occupancy < 3'd2);
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rd_en     = issue;
    rd_addr   = cur_addr_q;
    out_data  = fifo_data_q[rd_ptr_q];
    out_sop   = fifo_sop_q[rd_ptr_q];
    out_eop   = fifo_eop_q[rd_ptr_q];
  end

  // Descriptor FSM: latch on accept, issue reads with wrap, drain the FIFO.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    first_d    = first_q;
    inflight_d = issue;
    infl_sop_d = first_q;
    infl_eop_d = (remain_q == LEN_WIDTH'(1));
    case (state_q)
      IDLE: begin
        if (req_valid && (req_len != '0)) begin
          cur_addr_d = req_addr;
          remain_d   = req_len;
          first_d    = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (issue) begin
          remain_d   = remain_q - LEN_WIDTH'(1);
          first_d    = 1'b0;
          cur_addr_d = (cur_addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 :
                       cur_addr_q + ADDR_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the last word is popped so req_ready returns next cycle.
        if (!inflight_q && (fifo_cnt_d == 2'd0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry FIFO: SRAM data lands here the cycle after each read.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_sop_d  = fifo_sop_q;
    fifo_eop_d  = fifo_eop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      fifo_data_d[wr_ptr_q] = rd_data;
      fifo_sop_d[wr_ptr_q]  = infl_sop_q;
      fifo_eop_d[wr_ptr_q]  = infl_eop_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // State registers; reset drops any partial packet and in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      first_q     <= 1'b0;
      inflight_q  <= 1'b0;
      infl_sop_q  <= 1'b0;
      infl_eop_q  <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_sop_q  <= '0;
      fifo_eop_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      first_q     <= first_d;
      inflight_q  <= inflight_d;
      infl_sop_q  <= infl_sop_d;
      infl_eop_q  <= infl_eop_d;
      fifo_data_q <= fifo_data_d;
      fifo_sop_q  <= fifo_sop_d;
      fifo_eop_q  <= fifo_eop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // The credit check should make a push into a full, non-draining FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && (fifo_cnt_q == 2'd2)));

endmodule

// File: tb/tb_sram_rd_engine.sv
// Directed bench for sram_rd_engine with a behavioural one-cycle SRAM.
module tb_sram_rd_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_addr;
  logic [6:0]  req_len;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [15:0] rd_data = 16'h0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        busy;

  int passCount  = 0;
  int checkCount = 0;

  sram_rd_engine dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
  );

  always #5 clk = ~clk;

  // Preloaded SRAM contents as a pure function of address.
  function automatic logic [15:0] sramWord(input logic [13:0] a);
    return {a, 2'b10} ^ 16'h3C5A;
  endfunction

  // SRAM read port: data appears the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= sramWord(rd_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Run one descriptor; pattern 0 keeps out_ready high, pattern 1 is 1,0,0 repeating.
  // With chain set, req_valid stays high and presents the next descriptor.
  task automatic applyStimulus(input logic [13:0] addr, input int len, input int pattern,
                               input logic chain, input logic [13:0] nAddr,
                               input logic [6:0] nLen);
    int issued = 0, popped = 0, maxOcc = 0;
    int firstRd = -1, firstVal = -1, lastPop = -1;
    logic [13:0] expAddr, wordAddr;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = 7'(len);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = chain;
    if (chain) begin
      req_addr = nAddr;
      req_len  = nLen;
    end
    for (int c = 1; c < 200 && popped < len; c++) begin
      out_ready = (pattern == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      #1;
      if (rd_en) begin
        expAddr = 14'(addr + 14'(issued));
        checkOutput("rd_addr", 32'(rd_addr), 32'(expAddr));
        if (firstRd < 0) firstRd = c;
        issued++;
      end
      if (out_valid) begin
        wordAddr = 14'(addr + 14'(popped));
        if (firstVal < 0) firstVal = c;
        checkOutput("word", 32'({out_sop, out_eop, out_data}),
                    32'({popped == 0, popped == len - 1, sramWord(wordAddr)}));
        if (out_ready) begin
          popped++;
          lastPop = c;
        end
      end
      if (issued - popped > maxOcc) maxOcc = issued - popped;
      @(negedge clk);
    end
    #1;
    checkOutput("pop_count", 32'(popped), 32'(len));
    checkOutput("rd_count", 32'(issued), 32'(len));
    checkOutput("max_occ_le2", 32'(maxOcc <= 2), 32'd1);
    checkOutput("req_ready_after_eop", 32'(req_ready), 32'd1);
    if (pattern == 0) begin
      checkOutput("first_rd_cycle", 32'(firstRd), 32'd1);
      checkOutput("first_valid_cycle", 32'(firstVal), 32'd3);
      checkOutput("last_pop_cycle", 32'(lastPop), 32'(len + 2));
    end
  endtask

  initial begin
    int rdSeen, validSeen, busySeen, popped;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_out", 32'({out_valid, out_sop, out_eop, out_data}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic len 4 at 0x10");
    applyStimulus(14'h0010, 4, 0, 1'b0, '0, '0);
    $display("[TB] wrap at 16382");
    applyStimulus(14'd16382, 4, 0, 1'b0, '0, '0);
    $display("[TB] len 8 with backpressure");
    applyStimulus(14'h0100, 8, 1, 1'b0, '0, '0);
    $display("[TB] single word");
    applyStimulus(14'h0033, 1, 0, 1'b0, '0, '0);

    $display("[TB] zero length descriptor");
    req_valid = 1'b1; req_addr = 14'h0005; req_len = 7'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rdSeen = 0; validSeen = 0; busySeen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      rdSeen    += int'(rd_en);
      validSeen += int'(out_valid);
      busySeen  += int'(busy);
      @(negedge clk);
    end
    checkOutput("len0_rd_en", 32'(rdSeen), 32'd0);
    checkOutput("len0_valid", 32'(validSeen), 32'd0);
    checkOutput("len0_busy", 32'(busySeen), 32'd0);

    $display("[TB] back-to-back len 3 then len 2");
    applyStimulus(14'h0200, 3, 0, 1'b1, 14'h0300, 7'd2);
    applyStimulus(14'h0300, 2, 0, 1'b0, '0, '0);

    $display("[TB] reset mid-packet");
    req_valid = 1'b1; req_addr = 14'h0400; req_len = 7'd6; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    popped = 0;
    for (int c = 0; c < 20 && popped < 2; c++) begin
      #1;
      if (out_valid) popped++;
      @(negedge clk);
    end
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out", 32'({out_valid, out_sop, out_eop, out_data}), 32'd0);
    checkOutput("mid_rst_rd", 32'({rd_en, rd_addr}), 32'd0);
    checkOutput("mid_rst_ctrl", 32'({req_ready, busy}), 32'b10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(14'h0500, 2, 0, 1'b0, '0, '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard stop in case a wait ever runs away.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_rd_engine.md
# sram_rd_engine

Read-side stage sitting directly downstream of the packet-buffer `sram`. It accepts a read descriptor (start address, word count), drives the SRAM read port with wrap-around addressing, and absorbs the one-cycle SRAM read latency in a 2-entry output FIFO. Words leave as a valid/ready stream with SOP/EOP markers at up to one word per cycle under full backpressure control.

## Interface
- `ADDR_WIDTH`, 14, SRAM address width
- `DATA_WIDTH`, 16, SRAM word width
- `DATA_DEPTH`, 16384, SRAM depth in words; address wrap point
- `LEN_WIDTH`, 7, width of descriptor word count
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  descriptor valid
- `req_ready`  out  1  descriptor accepted when `req_valid && req_ready`
- `req_addr`  in  ADDR_WIDTH  first word address
- `req_len`  in  LEN_WIDTH  number of words, 0..2^LEN_WIDTH-1
- `rd_en`  out  1  to SRAM `rd_en`
- `rd_addr`  out  ADDR_WIDTH  to SRAM `rd_addr`
- `rd_data`  in  DATA_WIDTH  from SRAM `dout`, valid the cycle after `rd_en`
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accepts word
- `out_data`  out  DATA_WIDTH  output word
- `out_sop`  out  1  first word of descriptor
- `out_eop`  out  1  last word of descriptor
- `busy`  out  1  descriptor in progress

## Operation
- States: IDLE, READ, DRAIN. `req_ready = (state==IDLE)`; `busy = (state!=IDLE)`.
- IDLE: on handshake with `req_len!=0`, latch `cur_addr=req_addr`, `remain=req_len`, `first=1`, go READ. Handshake with `req_len==0`: consumed, no reads, no output, stay IDLE.
- READ: issue condition `issue = (remain!=0) && (fifo_cnt + inflight - pop) < 2`, where `pop = out_valid && out_ready`, `inflight` = `rd_en` of previous cycle. On issue: `rd_en=1`, `rd_addr=cur_addr`, `remain--`, `cur_addr = (cur_addr==DATA_DEPTH-1) ? 0 : cur_addr+1`. When final word is issued, go DRAIN.
- Read data: cycle after `rd_en`, `rd_data` is pushed into FIFO with tags `sop` (first issued word of descriptor) and `eop` (last issued word). FIFO never overflows by construction; overflow is a design error (assertion).
- DRAIN: no issues; when `fifo_cnt==0`, `inflight==0`, go IDLE.
- Output: `out_valid = fifo_cnt!=0`; `out_data/out_sop/out_eop` from FIFO head, held stable while `out_valid && !out_ready`.
- `rd_en` is combinational from state/counters; `rd_addr` driven only meaningfully when `rd_en=1` (held at `cur_addr` otherwise).
- Reset (any time, incl. mid-descriptor): state IDLE, FIFO and inflight cleared, in-flight SRAM data discarded, no partial packet resumes.

## Timing
- Reset values: `req_ready=1` (in IDLE), `rd_en=0`, `rd_addr=0`, `out_valid=0`, `out_data=0`, `out_sop=0`, `out_eop=0`, `busy=0`.
- Descriptor accepted at edge E0. First `rd_en` in cycle E0+1. Data captured at end of E0+2. First `out_valid` in cycle E0+3 (latency 3).
- With `out_ready` held 1: one `rd_en` per cycle, one output word per cycle, no bubbles; last word for length N appears in cycle E0+N+2.
- `out_ready=0` stalls issue after at most 2 words buffered/in-flight; resumes the cycle `out_ready` returns.
- `req_ready` reasserts the cycle after the EOP word is popped; next descriptor can be accepted that cycle.
- Wrap: address DATA_DEPTH-1 is followed by 0 within one descriptor.

## Test plan
- Reset, `req_addr=0x0010`, `req_len=4`, `out_ready=1` -> `rd_addr` 0x10,0x11,0x12,0x13 in cycles 1-4; outputs cycles 3-6 with SOP on word 0, EOP on word 3; `req_ready` high in cycle 7.
- `req_addr=16382`, `req_len=4` -> `rd_addr` sequence 16382,16383,0,1; data matches preloaded SRAM contents.
- `req_len=8`, `out_ready` toggling 1,0,0,1,... -> no word lost/duplicated, data stable during stall, never more than 2 words buffered+in-flight.
- `req_len=1` -> single word with `out_sop=1` and `out_eop=1`; `req_len=0` -> accepted, no `rd_en`, no `out_valid`, `busy` stays 0.
- Back-to-back descriptors (len 3 then len 2) with `req_valid` held -> second accepted the cycle after first EOP pop; SOP/EOP correct per packet.
- Assert `rst_n=0` mid-packet after 2 of 6 words output -> all outputs return to reset values immediately; after release, new descriptor len 2 outputs exactly 2 correct words.
